// File: rtl/wallace_tree_reduction.sv
// 5x5 unsigned Wallace tree: 25 partial products reduced to sum/carry rows, registered.
// Define WALLACE_PRODUCT_EN to add a ripple-carry adder and a registered product port.
module wallace_tree_reduction (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       in_valid,
  output logic [9:0] r1,
  output logic [9:0] r2,
  output logic       out_valid
`ifdef WALLACE_PRODUCT_EN
  ,
  output logic [9:0] product
`endif
);

  localparam int W = 10;

  // Column occupancy of each row; drives FA/HA/wire selection per column.
  localparam logic [W-1:0] M0 = 10'h01f;
  localparam logic [W-1:0] M1 = 10'h03e;
  localparam logic [W-1:0] M2 = 10'h07c;
  localparam logic [W-1:0] M3 = 10'h0f8;
  localparam logic [W-1:0] M4 = 10'h1f0;

  localparam logic [W-1:0] MS0 = M0 | M1 | M2;
  localparam logic [W-1:0] MC0 =
    ((M0 & M1) | (M0 & M2) | (M1 & M2)) << 1;
  localparam logic [W-1:0] MS1 = MS0 | MC0 | M3;
  localparam logic [W-1:0] MC1 =
    ((MS0 & MC0) | (MS0 & M3) | (MC0 & M3)) << 1;

  localparam logic [2:0][W-1:0] MX = {MS1, MS0, M0};
  localparam logic [2:0][W-1:0] MY = {MC1, MC0, M1};
  localparam logic [2:0][W-1:0] MZ = {M4, M3, M2};

  function automatic logic [1:0] fa(
    input logic x_i,
    input logic y_i,
    input logic z_i
  );
    return {(x_i & y_i) | (x_i & z_i) | (y_i & z_i),
            x_i ^ y_i ^ z_i};
  endfunction

  function automatic logic [1:0] ha(
    input logic x_i,
    input logic y_i
  );
    return {x_i & y_i, x_i ^ y_i};
  endfunction

  logic [4:0][W-1:0] pp;
  logic [2:0][W-1:0] x;
  logic [2:0][W-1:0] y;
  logic [2:0][W-1:0] z;
  logic [2:0][W-1:0] s;
  logic [2:0][W-1:0] c;
  logic [2:0][W-1:0] cy;

  for (genvar i = 0; i < 5; i++) begin : g_pp
    assign pp[i] = {5'b0, a & {5{b[i]}}} << i;
  end

  // Compressed rows go first, the leftover row joins the next group.
  assign x[0] = pp[0];
  assign y[0] = pp[1];
  assign z[0] = pp[2];
  assign x[1] = s[0];
  assign y[1] = c[0];
  assign z[1] = pp[3];
  assign x[2] = s[1];
  assign y[2] = c[1];
  assign z[2] = pp[4];

  for (genvar g = 0; g < 3; g++) begin : g_stage
    for (genvar k = 0; k < W; k++) begin : g_col
      localparam bit HX = MX[g][k];
      localparam bit HY = MY[g][k];
      localparam bit HZ = MZ[g][k];
      if (HX && HY && HZ) begin : g_fa
        assign {cy[g][k], s[g][k]} =
          fa(x[g][k], y[g][k], z[g][k]);
      end else if (HX && HY) begin : g_ha_xy
        assign {cy[g][k], s[g][k]} =
          ha(x[g][k], y[g][k]);
      end else if (HX && HZ) begin : g_ha_xz
        assign {cy[g][k], s[g][k]} =
          ha(x[g][k], z[g][k]);
      end else if (HY && HZ) begin : g_ha_yz
        assign {cy[g][k], s[g][k]} =
          ha(y[g][k], z[g][k]);
      end else if (HX) begin : g_px
        assign {cy[g][k], s[g][k]} = {1'b0, x[g][k]};
      end else if (HY) begin : g_py
        assign {cy[g][k], s[g][k]} = {1'b0, y[g][k]};
      end else if (HZ) begin : g_pz
        assign {cy[g][k], s[g][k]} = {1'b0, z[g][k]};
      end else begin : g_none
        assign {cy[g][k], s[g][k]} = 2'b00;
      end
    end
    assign c[g] = {cy[g][W-2:0], 1'b0};
  end

  logic unused_bits;
  assign unused_bits = ^{x, y, z, cy};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1        <= '0;
      r2        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        r1 <= s[2];
        r2 <= c[2];
      end
    end
  end

`ifdef WALLACE_PRODUCT_EN
  logic [W:0]   pc;
  logic [W-1:0] psum;

  assign pc[0] = 1'b0;

  for (genvar k = 0; k < W; k++) begin : g_rca
    assign {pc[k+1], psum[k]} = fa(s[2][k], c[2][k], pc[k]);
  end

  // Top carry is always 0: 31*31 fits in 10 bits.
  logic unused_cout;
  assign unused_cout = pc[W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product <= '0;
    end else if (in_valid) begin
      product <= psum;
    end
  end
`endif

endmodule

// File: tb/tb_wallace_tree_reduction.sv
// Directed bench for wallace_tree_reduction: reset, known products, hold, sweep.
// Row expectations come from a vector carry-save model of the three stages.
module tb_wallace_tree_reduction;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] a = '0;
  logic [4:0] b = '0;
  logic       in_valid = 1'b0;
  logic [9:0] r1;
  logic [9:0] r2;
  logic       out_valid;
`ifdef WALLACE_PRODUCT_EN
  logic [9:0] product;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wallace_tree_reduction dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .in_valid(in_valid),
    .r1(r1),
    .r2(r2),
    .out_valid(out_valid)
`ifdef WALLACE_PRODUCT_EN
    ,
    .product(product)
`endif
  );

  function automatic void csa(
    input  logic [9:0] p,
    input  logic [9:0] q,
    input  logic [9:0] t,
    output logic [9:0] so,
    output logic [9:0] co
  );
    so = p ^ q ^ t;
    co = ((p & q) | (p & t) | (q & t)) << 1;
  endfunction

  // Returns {carry_row, sum_row}.
  function automatic logic [19:0] tree_model(
    input logic [4:0] ma,
    input logic [4:0] mb
  );
    logic [9:0] p [5];
    logic [9:0] s1, c1, s2, c2, s3, c3;
    for (int i = 0; i < 5; i++)
      p[i] = mb[i] ? (10'(ma) << i) : 10'd0;
    csa(p[0], p[1], p[2], s1, c1);
    csa(s1, c1, p[3], s2, c2);
    csa(s2, c2, p[4], s3, c3);
    return {c3, s3};
  endfunction

  task automatic check(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_res(
    input string       tag,
    input logic [4:0]  ea,
    input logic [4:0]  eb,
    input logic [15:0] want
  );
    logic [19:0] m;
    m = tree_model(ea, eb);
    check({tag, ".valid"}, 16'(out_valid), 16'd1);
    check({tag, ".sum"}, 16'(r1) + 16'(r2), want);
    check({tag, ".r1"}, 16'(r1), 16'(m[9:0]));
    check({tag, ".r2"}, 16'(r2), 16'(m[19:10]));
`ifdef WALLACE_PRODUCT_EN
    check({tag, ".prod"}, 16'(product), want);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".r1"}, 16'(r1), 16'd0);
    check({tag, ".r2"}, 16'(r2), 16'd0);
    check({tag, ".valid"}, 16'(out_valid), 16'd0);
`ifdef WALLACE_PRODUCT_EN
    check({tag, ".prod"}, 16'(product), 16'd0);
`endif
  endtask

  task automatic apply(input logic [4:0] ai, input logic [4:0] bi);
    @(negedge clk);
    a = ai;
    b = bi;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [19:0] m750;

    // Reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #1 check_zero("rst_async");
    repeat (2) @(posedge clk);
    #1 check_zero("rst_held");

    // Operands present but not valid: nothing captured.
    @(negedge clk);
    rst = 1'b0;
    a = 5'd5;
    b = 5'd3;
    in_valid = 1'b0;
    @(posedge clk);
    #1 check_zero("post_rst_idle");

    apply(5'd5, 5'd3);
    check_res("5x3", 5'd5, 5'd3, 16'd15);

    apply(5'd31, 5'd31);
    check_res("31x31", 5'd31, 5'd31, 16'd961);

    apply(5'd10, 5'd20);
    check_res("b2b_10x20", 5'd10, 5'd20, 16'd200);
    apply(5'd1, 5'd0);
    check_res("b2b_1x0", 5'd1, 5'd0, 16'd0);
    apply(5'd30, 5'd25);
    check_res("b2b_30x25", 5'd30, 5'd25, 16'd750);

    // Three idle cycles hold the last result.
    m750 = tree_model(5'd30, 5'd25);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a = 5'd7;
      b = 5'd7;
      @(posedge clk);
      #1;
      check("hold.valid", 16'(out_valid), 16'd0);
      check("hold.sum", 16'(r1) + 16'(r2), 16'd750);
      check("hold.r1", 16'(r1), 16'(m750[9:0]));
      check("hold.r2", 16'(r2), 16'(m750[19:10]));
`ifdef WALLACE_PRODUCT_EN
      check("hold.prod", 16'(product), 16'd750);
`endif
    end

    // Reset between edges while a result is valid.
    apply(5'd7, 5'd9);
    check_res("pre_rst_7x9", 5'd7, 5'd9, 16'd63);
    #2 rst = 1'b1;
    #1 check_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 check_zero("rst_release");

    for (int ai = 0; ai < 32; ai++) begin
      for (int bi = 0; bi < 32; bi++) begin
        apply(5'(ai), 5'(bi));
        check_res($sformatf("sw%0dx%0d", ai, bi),
                  5'(ai), 5'(bi), 16'(ai * bi));
      end
    end

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 check("end.valid", 16'(out_valid), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wallace_tree_reduction.md
WALLACE_TREE_REDUCTION -- requirements
Module: wallace_tree_reduction

Interface
- REQ-001: clk  input  1  sole clock; all state updates on rising edge.
- REQ-002: rst  input  1  asynchronous, active-high reset.
- REQ-003: a  input  5  unsigned multiplicand.
- REQ-004: b  input  5  unsigned multiplier.
- REQ-005: in_valid  input  1  a/b valid this cycle.
- REQ-006: r1  output  10  registered sum row of the reduced tree.
- REQ-007: r2  output  10  registered carry row of the reduced tree.
- REQ-008: out_valid  output  1  r1/r2 hold a result for the operands captured on the previous edge.
- REQ-009: product  output  10  registered r1+r2; present only when WALLACE_PRODUCT_EN is defined.

Function
- REQ-010: The block SHALL form 25 partial products, pp[i][j] = a[j] & b[i], each of weight 2^(i+j).
- REQ-011: The block SHALL reduce the five partial-product rows to two rows using only full adders (3:2) and half adders (2:2), with no carry-propagate adder in the reduction.
- REQ-012: The reduction SHALL use three Wallace stages: 5 rows -> 4 -> 3 -> 2.
- REQ-013: In each stage, every complete group of three rows SHALL be compressed; leftover rows SHALL pass through unchanged.
- REQ-014: In each column, a column holding three bits SHALL use a full adder, and a column holding two bits SHALL use a half adder.
- REQ-015: Sum bits SHALL stay in their column; carry bits SHALL move one column up.
- REQ-016: For all 1024 operand pairs, the integer sum r1 + r2 SHALL equal a*b exactly; this bounds it at 961 maximum, with no bit beyond bit 9 and no discarded carry.
- REQ-017: Unused high bits of r1/r2 SHALL be driven 0.
- REQ-018: On each rising clk edge with in_valid=1, the block SHALL register the reduced rows of the current a/b into r1/r2 and set out_valid=1; latency is 1 cycle, with one new operand pair accepted per cycle.
- REQ-019: On each rising clk edge with in_valid=0, out_valid SHALL go to 0 and r1/r2 (and product) SHALL hold their previous values.
- REQ-020: No handshake back-pressure exists; outputs are overwritten every valid cycle.
- REQ-021: There SHALL be no combinational path from inputs to outputs.

Reset
- REQ-022: While rst=1, r1, r2, product and out_valid SHALL be 0 immediately, independent of clk.
- REQ-023: The first capture after rst deasserts SHALL occur on the first rising edge with rst=0 and in_valid=1.
- REQ-024: Asserting rst mid-stream SHALL discard the in-flight result, and out_valid SHALL read 0 on the next edge after release unless in_valid=1.

Configuration
- REQ-025: When the macro WALLACE_PRODUCT_EN is defined, the block SHALL contain an internal 10-bit ripple-carry adder.
- REQ-026: With WALLACE_PRODUCT_EN defined, product SHALL be registered alongside r1/r2 with the same latency and reset, and SHALL equal a*b.
- REQ-027: With WALLACE_PRODUCT_EN undefined, the product port and its adder SHALL be absent, and r1/r2 behaviour SHALL be identical to the defined case.

Verification
- REQ-028: a=5, b=3, in_valid=1 -> one edge later out_valid=1 and r1+r2=15 (product=15 when enabled).
- REQ-029: a=31, b=31 -> r1+r2=961 with no overflow beyond 10 bits.
- REQ-030: Back-to-back operand pairs on consecutive cycles -> successive results 200, then 0, then 750, one per cycle:
  - a=10, b=20 -> 200
  - a=1, b=0 -> 0
  - a=30, b=25 -> 750
- REQ-031: Exhaustive sweep of all 32x32 operand pairs -> every result satisfies r1+r2 == a*b, with r1 and r2 compared individually against a bit-accurate tree model.
- REQ-032: Assert rst asynchronously between edges while out_valid=1 -> r1, r2 and out_valid drop to 0 at once; with in_valid=0 after release, outputs remain 0.
- REQ-033: in_valid=0 for 3 cycles after a result of 750 -> r1/r2 hold that result and out_valid=0.
